// File: rtl/fetch_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module      : fetch_unit_pkg
// Description : Shared defaults and the fetch FSM state type for the
//               instruction fetch unit and its skid buffer.
// Revision    : 1.0 - initial release
//==============================================================================
package fetch_unit_pkg;

   localparam int          PC_W_DEFAULT     = 21;
   localparam int          INSTR_W_DEFAULT  = 32;
   localparam int          PC_STEP_DEFAULT  = 4;
   localparam int unsigned RESET_PC_DEFAULT = 0;

   // S_REQ   : request presented to memory
   // S_WAIT  : one request outstanding, response will be used
   // S_DRAIN : one request outstanding, response is stale and will be dropped
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_e;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
//==============================================================================
// Module      : fetch_skid_buf
// Description : One-entry holding buffer (instruction + PC) that catches a
//               fetch response arriving while decode is stalled.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_skid_buf
   import fetch_unit_pkg::*;
#(
   parameter int PC_W    = PC_W_DEFAULT,
   parameter int INSTR_W = INSTR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               fill_i,
   input  logic               drain_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [PC_W-1:0]    pc_i,
   output logic               full_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    pc_o
);

   logic               full_q;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    pc_q;

   // Clear (flush) beats fill; fill and drain never coincide in the fetch unit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         full_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         full_q  <= 1'b0;
      end else if (fill_i) begin
         full_q  <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         full_q  <= 1'b0;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with a single outstanding memory
//               request, flush/redirect handling and an IF/ID register
//               backed by a one-entry skid buffer for decode stalls.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          PC_W     = PC_W_DEFAULT,
   parameter int          INSTR_W  = INSTR_W_DEFAULT,
   parameter int          PC_STEP  = PC_STEP_DEFAULT,
   parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               stall,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    next_pc_if,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [PC_W-1:0]    if_id_pc
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;          // next address to request
   logic [PC_W-1:0]    req_pc_q, req_pc_d;  // address of the outstanding request
   logic               ifv_q, ifv_d;
   logic [INSTR_W-1:0] ifi_q, ifi_d;
   logic [PC_W-1:0]    ifp_q, ifp_d;

   logic               hs;
   logic               rsp_take;
   logic               skid_full;
   logic               skid_fill;
   logic               skid_drain;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   // Request only when idle in S_REQ and there is room for the response.
   assign imem_req   = rst && (state_q == S_REQ) && !skid_full;
   assign imem_addr  = pc_q;
   assign next_pc_if = pc_q + PC_W'(PC_STEP);
   assign hs         = imem_req && imem_gnt;
   // A response is usable only in S_WAIT and only if no flush squashes it.
   assign rsp_take   = (state_q == S_WAIT) && imem_rvalid && !flush;

   // Fetch FSM and PC: advance on handshake, redirect on flush.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      case (state_q)
         S_REQ: begin
            if (hs) begin
               state_d  = flush ? S_DRAIN : S_WAIT;
               req_pc_d = pc_q;
               pc_d     = next_pc_if;
            end
         end
         S_WAIT: begin
            if (imem_rvalid)  state_d = S_REQ;
            else if (flush)   state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (imem_rvalid)  state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      if (flush) pc_d = redirect_pc;
   end

   // IF/ID update: flush clears, stall holds (overflow to skid), else load or bubble.
   always_comb begin
      ifv_d      = ifv_q;
      ifi_d      = ifi_q;
      ifp_d      = ifp_q;
      skid_fill  = 1'b0;
      skid_drain = 1'b0;
      if (flush) begin
         ifv_d = 1'b0;
      end else if (stall) begin
         if (rsp_take) begin
            if (ifv_q) begin
               skid_fill = 1'b1;
            end else begin
               // IF/ID is empty, so nothing live is disturbed by loading it.
               ifv_d = 1'b1;
               ifi_d = imem_rdata;
               ifp_d = req_pc_q;
            end
         end
      end else if (skid_full) begin
         ifv_d      = 1'b1;
         ifi_d      = skid_instr;
         ifp_d      = skid_pc;
         skid_drain = 1'b1;
      end else if (rsp_take) begin
         ifv_d = 1'b1;
         ifi_d = imem_rdata;
         ifp_d = req_pc_q;
      end else begin
         ifv_d = 1'b0;
      end
   end

   // State, PC and IF/ID registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_REQ;
         pc_q     <= PC_W'(RESET_PC);
         req_pc_q <= '0;
         ifv_q    <= 1'b0;
         ifi_q    <= '0;
         ifp_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         ifv_q    <= ifv_d;
         ifi_q    <= ifi_d;
         ifp_q    <= ifp_d;
      end
   end

   fetch_skid_buf #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .fill_i  (skid_fill),
      .drain_i (skid_drain),
      .instr_i (imem_rdata),
      .pc_i    (req_pc_q),
      .full_o  (skid_full),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   assign if_id_valid = ifv_q;
   assign if_id_instr = ifi_q;
   assign if_id_pc    = ifp_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with a single-outstanding
//               memory model and an in-order delivery scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fetch_unit;

   localparam int PC_W    = 21;
   localparam int INSTR_W = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic [PC_W-1:0]    redirect_pc;
   logic               stall;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic [PC_W-1:0]    next_pc_if;
   logic               if_id_valid;
   logic [INSTR_W-1:0] if_id_instr;
   logic [PC_W-1:0]    if_id_pc;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .next_pc_if  (next_pc_if),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } exp_t;

   exp_t            sb_q[$];
   logic [PC_W-1:0] hs_addr_q[$];
   int              hs_cyc_q[$];
   logic [PC_W-1:0] dv_pc_q[$];
   int              dv_cyc_q[$];

   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              rel_cyc  = 0;

   bit              gnt_en   = 1'b0;
   int              resp_lat = 1;
   bit              mem_pend = 1'b0;
   bit              mem_stale = 1'b0;
   int              mem_cnt  = 0;
   logic [PC_W-1:0] mem_addr = '0;

   bit              mon_v    = 1'b0;
   logic [PC_W-1:0] mon_pc   = '0;

   function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
      return {8'hC3, 3'b000, pc};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: one outstanding request, response after resp_lat cycles.
   // A request is stale if a flush or reset is seen at its grant edge or any
   // later edge up to and including its response edge.
   always @(negedge clk) begin
      #1;
      imem_rvalid = 1'b0;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_addr);
            mem_pend    = 1'b0;
            if (!mem_stale && !flush && rst)
               sb_q.push_back({mem_addr, instr_of(mem_addr)});
         end else begin
            mem_cnt--;
            if (flush || !rst) mem_stale = 1'b1;
         end
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
         mem_pend  = 1'b1;
         mem_addr  = imem_addr;
         mem_cnt   = resp_lat;
         mem_stale = flush;
         hs_addr_q.push_back(imem_addr);
         hs_cyc_q.push_back(cyc + 1);
      end
   end

   // Delivery monitor: each newly loaded IF/ID entry is popped from the scoreboard.
   always @(negedge clk) begin
      #3;
      if (!rst) begin
         mon_v = 1'b0;
      end else begin
         if (if_id_valid && (!mon_v || if_id_pc != mon_pc)) begin
            dv_pc_q.push_back(if_id_pc);
            dv_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
               check("sb_extra", 64'(sb_q.size()), 64'd1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_pc", 64'(if_id_pc), 64'(e.pc));
               check("sb_instr", 64'(if_id_instr), 64'(e.instr));
            end
         end
         mon_v  = if_id_valid;
         mon_pc = if_id_pc;
      end
   end

   task automatic do_reset(input bit gnt);
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; stall = 1'b0; gnt_en = gnt;
      repeat (4) @(negedge clk);
      #2;
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(if_id_valid), 64'd0);
      check("rst_pc", 64'(if_id_pc), 64'd0);
      check("rst_instr", 64'(if_id_instr), 64'd0);
      sb_q.delete(); hs_addr_q.delete(); hs_cyc_q.delete();
      dv_pc_q.delete(); dv_cyc_q.delete();
      @(negedge clk);
      rst = 1'b1;
      rel_cyc = cyc;
      #2;
      check("rel_req", 64'(imem_req), 64'd1);
      check("rel_addr", 64'(imem_addr), 64'd0);
   endtask

   task automatic wait_hs(input int n, input int budget);
      int b = budget;
      do begin
         @(negedge clk);
         b--;
      end while (hs_addr_q.size() < n && b > 0);
      if (hs_addr_q.size() < n) check("timeout_hs", 64'(hs_addr_q.size()), 64'(n));
   endtask

   task automatic wait_dv(input int n, input int budget);
      int b = budget;
      do begin
         @(negedge clk);
         b--;
      end while (dv_pc_q.size() < n && b > 0);
      if (dv_pc_q.size() < n) check("timeout_dv", 64'(dv_pc_q.size()), 64'(n));
   endtask

   initial begin
      int b;
      rst = 1'b0; flush = 1'b0; stall = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

      // Streaming fetch: 1-cycle latency, always granted, no stall.
      resp_lat = 1;
      do_reset(1'b1);
      wait_dv(3, 40);
      if (hs_addr_q.size() >= 3 && dv_pc_q.size() >= 3) begin
         check("s_hs0", 64'(hs_addr_q[0]), 64'h0);
         check("s_hs1", 64'(hs_addr_q[1]), 64'h4);
         check("s_hs2", 64'(hs_addr_q[2]), 64'h8);
         check("s_hs0_cyc", 64'(hs_cyc_q[0]), 64'(rel_cyc + 1));
         check("s_dv0", 64'(dv_pc_q[0]), 64'h0);
         check("s_dv2", 64'(dv_pc_q[2]), 64'h8);
         check("s_dv0_cyc", 64'(dv_cyc_q[0]), 64'(rel_cyc + 2));
         check("s_gap1", 64'(dv_cyc_q[1] - dv_cyc_q[0]), 64'd2);
         check("s_gap2", 64'(dv_cyc_q[2] - dv_cyc_q[1]), 64'd2);
      end

      // Flush while waiting on the addr-8 response.
      resp_lat = 3;
      do_reset(1'b1);
      wait_hs(3, 60);
      flush = 1'b1; redirect_pc = 21'h100;
      @(negedge clk);
      flush = 1'b0;
      #2;
      check("fw_req_drain", 64'(imem_req), 64'd0);
      check("fw_valid", 64'(if_id_valid), 64'd0);
      check("fw_addr", 64'(imem_addr), 64'h100);
      wait_hs(4, 40);
      if (hs_addr_q.size() >= 4) check("fw_hs_redirect", 64'(hs_addr_q[3]), 64'h100);
      wait_dv(3, 40);
      if (dv_pc_q.size() >= 3) check("fw_dv_redirect", 64'(dv_pc_q[2]), 64'h100);

      // Stall for 5 cycles while a response arrives.
      resp_lat = 1;
      do_reset(1'b1);
      b = 40;
      do begin
         @(negedge clk);
         #2;
         b--;
      end while (!if_id_valid && b > 0);
      check("st_first_valid", 64'(if_id_valid), 64'd1);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         check("st_hold_valid", 64'(if_id_valid), 64'd1);
         check("st_hold_pc", 64'(if_id_pc), 64'h0);
         check("st_hold_instr", 64'(if_id_instr), 64'(instr_of(21'h0)));
         check("st_req_off", 64'(imem_req), 64'd0);
      end
      stall = 1'b0;
      @(negedge clk);
      #2;
      check("st_drain_pc", 64'(if_id_pc), 64'h4);
      check("st_drain_valid", 64'(if_id_valid), 64'd1);
      check("st_resume_req", 64'(imem_req), 64'd1);
      check("st_resume_addr", 64'(imem_addr), 64'h8);
      wait_dv(3, 40);

      // Flush and response in the same cycle (IF/ID held valid by stall).
      resp_lat = 1;
      do_reset(1'b1);
      b = 40;
      do begin
         @(negedge clk);
         #2;
         b--;
      end while (!if_id_valid && b > 0);
      stall = 1'b1;
      wait_hs(2, 40);
      flush = 1'b1; redirect_pc = 21'h200;
      @(negedge clk);
      flush = 1'b0; stall = 1'b0;
      #2;
      check("fr_valid", 64'(if_id_valid), 64'd0);
      check("fr_req", 64'(imem_req), 64'd1);
      check("fr_addr", 64'(imem_addr), 64'h200);
      wait_dv(2, 40);
      if (dv_pc_q.size() >= 2) check("fr_dv_redirect", 64'(dv_pc_q[1]), 64'h200);

      // Grant withheld for 3 cycles.
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         check("ng_req", 64'(imem_req), 64'd1);
         check("ng_addr", 64'(imem_addr), 64'h0);
         check("ng_no_hs", 64'(hs_addr_q.size()), 64'd0);
         check("ng_valid", 64'(if_id_valid), 64'd0);
      end
      gnt_en = 1'b1;
      wait_hs(1, 20);
      if (hs_addr_q.size() >= 1) check("ng_hs_addr", 64'(hs_addr_q[0]), 64'h0);
      wait_dv(1, 20);

      // Flush on a granted request, redirect to the top of the PC space.
      do_reset(1'b0);
      @(negedge clk);
      gnt_en = 1'b1; flush = 1'b1; redirect_pc = 21'h1FFFFC;
      @(negedge clk);
      flush = 1'b0;
      #2;
      check("wr_req_drain", 64'(imem_req), 64'd0);
      check("wr_addr", 64'(imem_addr), 64'h1FFFFC);
      check("wr_next_pc", 64'(next_pc_if), 64'h0);
      wait_dv(2, 40);
      if (dv_pc_q.size() >= 2) begin
         check("wr_dv0", 64'(dv_pc_q[0]), 64'h1FFFFC);
         check("wr_dv1", 64'(dv_pc_q[1]), 64'h0);
      end

      // Quiesce and make sure every expected instruction was delivered.
      @(negedge clk);
      gnt_en = 1'b0;
      repeat (8) @(negedge clk);
      #4;
      check("sb_leftover", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_fetch_unit
`default_nettype wire
